// File: rtl/probe_uart_tx.sv
// probe_uart_tx
//   Byte-wide valid/ready to 8N1 serial transmitter. Bytes are buffered in a
//   small FIFO and a new frame starts only while the receiver asserts rts_in.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   tx_data     byte to send
//   valid_in    tx_data valid; accepted when valid_in && ready
//   ready       FIFO not full
//   rts_in      receiver can accept a new frame (sampled at frame start only)
//   tx_out      registered serial line, idles high
//   busy        frame on the line (START/DATA/STOP)
//   fifo_level  queued bytes, not counting the byte being shifted
//
// state | meaning
// IDLE  | line high, waiting for a queued byte and rts_in
// START | start bit (low) for one bit time
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (high); may chain straight into the next START
module probe_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          valid_in,
  output logic                          ready,
  input  logic                          rts_in,
  output logic                          tx_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // FIFO
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push;
  logic             w_pop;

  // FSM / shifter
  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_next;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             w_tx_next;
  logic             w_baud_done;
  logic             w_can_start;

  assign ready      = (r_level != LVL_FULL);
  assign fifo_level = r_level;
  assign tx_out     = r_tx;
  assign w_push     = valid_in && ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign w_baud_done = (r_cnt == CNT_LAST);
  assign w_can_start = (r_level != '0) && rts_in;

  // State register (tx_out is registered from the next-state decode)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_bit_idx <= w_bit_idx_next;
      r_tx      <= w_tx_next;
      if (w_pop) r_shift <= r_mem[r_rd_ptr];
      // Counter parks at 0 in IDLE so a new START always begins at 0.
      if (r_state == S_IDLE || w_baud_done) r_cnt <= '0;
      else                                  r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next   = r_state;
    w_bit_idx_next = r_bit_idx;
    w_pop          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_can_start) begin
          w_state_next = S_START;
          w_pop        = 1'b1;
        end
      end
      S_START: begin
        if (w_baud_done) begin
          w_state_next   = S_DATA;
          w_bit_idx_next = 3'd0;
        end
      end
      S_DATA: begin
        if (w_baud_done) begin
          if (r_bit_idx == 3'd7) w_state_next   = S_STOP;
          else                   w_bit_idx_next = r_bit_idx + 3'd1;
        end
      end
      S_STOP: begin
        if (w_baud_done) begin
          if (w_can_start) begin
            w_state_next = S_START;
            w_pop        = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_tx_next = 1'b1;
    busy      = (r_state != S_IDLE);
    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = r_shift[w_bit_idx_next];
      default: w_tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_probe_uart_tx.sv
// tb_probe_uart_tx
//   Self-checking bench for probe_uart_tx. A frame-timing reference model
//   (byte queue plus frame start time) is compared against the DUT every
//   cycle; directed sequences add hand-computed frame patterns and timings.
module tb_probe_uart_tx;
  localparam int C = 16;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       valid_in = 1'b0;
  logic       rts_in = 1'b1;
  logic       ready;
  logic       tx_out;
  logic       busy;
  logic [2:0] fifo_level;

  always #5 clk = ~clk;

  probe_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .valid_in   (valid_in),
    .ready      (ready),
    .rts_in     (rts_in),
    .tx_out     (tx_out),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // Reference model: queued bytes and the edge at which the current frame began.
  logic [7:0] mq[$];
  bit         m_act = 0;
  int         m_start = 0;
  int         m_k = 0;
  logic [7:0] m_byte = 8'h00;

  // Scenario results
  logic [7:0]  pb [4];
  logic [39:0] cap;
  int nrise, rise0, rise1, bcnt, last_b, max_lvl, min_rdy;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // {stop, data, start}, bit 0 first on the line
    int         drop;    // edge after acceptance at which busy falls
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", nm, m_k, act, exp);
    end
  endtask

  task automatic model_step();
    bit endf, idle, rdy, pop;
    m_k++;
    if (rst) begin
      mq.delete();
      m_act = 0;
    end else begin
      endf = m_act && ((m_k - m_start) == 10 * C);
      idle = !m_act || endf;
      rdy  = (mq.size() != D);
      pop  = idle && (mq.size() != 0) && rts_in;
      if (pop) begin
        m_byte  = mq.pop_front();
        m_act   = 1;
        m_start = m_k;
      end else if (endf) begin
        m_act = 0;
      end
      if (valid_in && rdy) mq.push_back(tx_data);
    end
  endtask

  function automatic logic m_txe();
    int ph;
    if (!m_act) return 1'b1;
    ph = (m_k - m_start) / C;
    if (ph == 0) return 1'b0;
    if (ph <= 8) return m_byte[ph-1];
    return 1'b1;
  endfunction

  task automatic tick();
    logic [5:0] a, e;
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (chk_en) begin
      a = {tx_out, busy, ready, fifo_level};
      e = {m_txe(), m_act, (mq.size() != D), 3'(mq.size())};
      chk("cycle_model", 64'(a), 64'(e));
    end
  endtask

  // Drives pushes of pb[0..n_push-1] on edges 0.., holds rts_in low on
  // edges [lo_beg, lo_end), and records busy rises plus mid-bit line samples.
  task automatic run_seq(input int n_push, input int lo_beg, input int lo_end, input int nedges);
    logic prev_b;
    int   last_rise, d, idx;
    prev_b = 1'b0; last_rise = 0;
    cap = '0; nrise = 0; rise0 = -1; rise1 = -1; bcnt = 0; last_b = -1;
    max_lvl = 0; min_rdy = 1;
    for (int k = 0; k < nedges; k++) begin
      valid_in = (k < n_push);
      tx_data  = pb[k & 3];
      rts_in   = !(k >= lo_beg && k < lo_end);
      tick();
      if (busy && !prev_b) begin
        if (nrise == 0) rise0 = k;
        else if (nrise == 1) rise1 = k;
        nrise++;
        last_rise = k;
      end
      if (busy) begin
        bcnt++;
        last_b = k;
        d = k - last_rise;
        if (d % C == C / 2) begin
          idx = (nrise - 1) * 10 + d / C;
          if (idx < 40) cap[idx] = tx_out;
        end
      end
      prev_b = busy;
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      if (!ready) min_rdy = 0;
    end
    valid_in = 1'b0;
    rts_in   = 1'b1;
  endtask

  initial begin
    int bad;
    tbl[0] = '{8'hA5, 10'h34A, 161};
    tbl[1] = '{8'h55, 10'h2AA, 161};
    tbl[2] = '{8'h0F, 10'h21E, 161};
    tbl[3] = '{8'hFF, 10'h3FE, 161};
    tbl[4] = '{8'h00, 10'h200, 161};
    tbl[5] = '{8'h3C, 10'h278, 161};
    tbl[6] = '{8'h7E, 10'h2FC, 161};

    // Reset and idle
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_en = 1;
    end
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if ({tx_out, busy, ready, fifo_level} !== 6'b101_000) bad++;
    end
    chk("idle_tx", 64'(tx_out), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_ready", 64'(ready), 64'd1);
    chk("idle_level", 64'(fifo_level), 64'd0);
    chk("idle_deviations", 64'(bad), 64'd0);

    // Single-byte frames from the table
    for (int i = 0; i < 7; i++) begin
      pb[0] = tbl[i].data;
      run_seq(1, 0, 0, 200);
      chk($sformatf("frame_%02h", tbl[i].data), 64'(cap[9:0]), 64'(tbl[i].frame));
      chk($sformatf("start_%02h", tbl[i].data), 64'(rise0), 64'd1);
      chk($sformatf("drop_%02h", tbl[i].data), 64'(last_b + 1), 64'(tbl[i].drop));
    end

    // Back-to-back frames
    pb[0] = 8'h55; pb[1] = 8'h0F; pb[2] = 8'hFF; pb[3] = 8'h00;
    run_seq(4, 0, 0, 700);
    chk("b2b_peak_level", 64'(max_lvl), 64'd3);
    chk("b2b_ready", 64'(min_rdy), 64'd1);
    chk("b2b_rises", 64'(nrise), 64'd1);
    chk("b2b_start", 64'(rise0), 64'd1);
    chk("b2b_busy_cycles", 64'(bcnt), 64'd640);
    chk("b2b_frames", 64'(cap), 64'({10'h200, 10'h3FE, 10'h21E, 10'h2AA}));

    // Full FIFO with rts_in low
    rts_in = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      valid_in = 1'b1;
      tx_data  = 8'(i);
      tick();
      chk($sformatf("full_level_%0d", i), 64'(fifo_level), 64'(i < 4 ? i : 4));
      chk($sformatf("full_ready_%0d", i), 64'(ready), 64'(i < 4));
    end
    valid_in = 1'b0;
    run_seq(0, 0, 0, 700);
    chk("full_rises", 64'(nrise), 64'd1);
    chk("full_start", 64'(rise0), 64'd0);
    chk("full_busy_cycles", 64'(bcnt), 64'd640);
    chk("full_frames", 64'(cap), 64'({10'h208, 10'h206, 10'h204, 10'h202}));

    // Flow control: rts_in low from cycle 40 of the first frame
    pb[0] = 8'h3C; pb[1] = 8'h7E;
    run_seq(2, 41, 201, 400);
    chk("flow_rises", 64'(nrise), 64'd2);
    chk("flow_start0", 64'(rise0), 64'd1);
    chk("flow_start1", 64'(rise1), 64'd201);
    chk("flow_busy_cycles", 64'(bcnt), 64'd320);
    chk("flow_frames", 64'(cap[19:0]), 64'({10'h2FC, 10'h278}));

    // Reset during DATA bit 3 with two bytes queued
    pb[0] = 8'hC3; pb[1] = 8'h96; pb[2] = 8'h81;
    for (int k = 0; k <= 73; k++) begin
      valid_in = (k < 3);
      tx_data  = pb[k & 3];
      tick();
    end
    valid_in = 1'b0;
    chk("midrst_pre_busy", 64'(busy), 64'd1);
    chk("midrst_pre_level", 64'(fifo_level), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_tx", 64'(tx_out), 64'd1);
    chk("midrst_level", 64'(fifo_level), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (busy) bad++;
    end
    chk("midrst_no_frames", 64'(bad), 64'd0);

    // Randomised traffic against the model
    for (int k = 0; k < 4000; k++) begin
      valid_in = ($urandom_range(0, 9) < 3);
      tx_data  = 8'($urandom);
      if ($urandom_range(0, 59) == 0) rts_in = !rts_in;
      tick();
    end
    valid_in = 1'b0;
    rts_in   = 1'b1;
    for (int k = 0; k < 800; k++) tick();
    chk("drain_level", 64'(fifo_level), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/probe_uart_tx.md
Name: probe_uart_tx

Overview:
- Bench-side UART transmitter that drives the SoC's UART rx line from a byte-wide valid/ready port.
- Sits upstream of the SoC UART receiver: buffers bytes in a small FIFO and serialises them as 8N1 frames.
- Honours the SoC's rts output: a new frame starts only while the SoC signals it can accept data.
- Used by the SoC testbench to inject console input; it is also reusable as a synthesizable TX in FPGA wrappers.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per UART bit; legal range 2..65535.
- FIFO_DEPTH, 4: byte FIFO entries; power of two, range 2..16.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- tx_data  input  8  byte to send.
- valid_in  input  1  tx_data valid; a byte is accepted on a rising edge where valid_in && ready.
- ready  output  1  FIFO not full.
- rts_in  input  1  SoC request-to-send; 1 = receiver may accept a new frame.
- tx_out  output  1  serial line to SoC rx; idles high.
- busy  output  1  1 while a frame is on the line (states START/DATA/STOP).
- fifo_level  output  $clog2(FIFO_DEPTH)+1  number of bytes queued, excluding the byte being shifted.

Behaviour:
- Reset values, applied on a rising edge with rst=1:
  - tx_out=1, busy=0, ready=1, fifo_level=0.
  - FSM=IDLE; FIFO pointers and counters cleared.
- Reset mid-frame: the frame is aborted and tx_out=1 from the next edge. Queued bytes are discarded.
- FIFO handshake:
  - ready = (fifo_level != FIFO_DEPTH).
  - Push on valid_in && ready. valid_in while ready=0 is ignored (no overwrite). tx_data is not required to hold after acceptance.
  - Pop occurs when the FSM starts a frame.
  - Push and pop on the same edge: fifo_level is unchanged and both take effect.
  - When full, ready=0 blocks a push even if a pop occurs on that edge.
- FSM states and transitions:
  - IDLE -> START: on an edge where fifo_level!=0 && rts_in=1. The head byte is popped into the shift register, the baud counter is cleared, and tx_out=0 from that edge.
  - START: one bit time, CLKS_PER_BIT cycles. Then -> DATA with bit index 0.
  - DATA: 8 bits, LSB first, each lasting CLKS_PER_BIT cycles. tx_out = shift_reg[index]. After bit 7 -> STOP.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles. At the end of STOP, if fifo_level!=0 && rts_in=1, pop and go directly to START (back-to-back, no idle gap); otherwise -> IDLE.
- Latency:
  - A byte accepted at edge N into an empty FIFO while in IDLE with rts_in=1 gives a start bit beginning at edge N+1.
  - The frame lasts exactly 10*CLKS_PER_BIT cycles.
- rts_in:
  - Sampled only at a frame-start decision.
  - Deassertion mid-frame does not stall or truncate the current frame.
  - While rts_in=0, the FSM stays in IDLE with tx_out=1 and queued bytes are retained.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary. No fractional or accumulated drift.
- busy=1 exactly while the FSM is START/DATA/STOP.
- tx_out is driven from a register (glitch-free, no combinational path from inputs).

Test Plan:
- Reset/idle: hold rst=1 for 5 cycles, then release with no input -> tx_out=1, busy=0, ready=1, fifo_level=0 for 100 cycles.
- Single byte, CLKS_PER_BIT=16: push 0xA5 at edge N with rts_in=1 -> tx_out falls at edge N+1, then line bits LSB-first 1,0,1,0,0,1,0,1, then stop=1. Each bit lasts 16 cycles; busy drops at edge N+161.
- Back-to-back: push 0x55, 0x0F, 0xFF, 0x00 on consecutive cycles -> fifo_level peaks at 3, ready stays 1, and four frames are sent contiguously (each stop bit followed immediately by a start bit) in 640 cycles.
- Full FIFO: rts_in=0, push 5 bytes (0x01..0x05) -> ready=0 after the 4th, the 5th is ignored and fifo_level=4. Raise rts_in -> exactly 0x01..0x04 are sent.
- Flow control: drop rts_in at cycle 40 of a frame (0x3C) with 0x7E queued -> the 0x3C frame completes intact, tx_out stays 1 while rts_in=0, and 0x7E starts the edge after rts_in returns to 1.
- Reset mid-frame: assert rst during DATA bit 3 with 2 bytes queued -> tx_out=1 and fifo_level=0 on the next edge. No further frames appear after release.
